// File: rtl/mor1kx_pic_scheduler_if.sv
// Bundle between the PIC scheduler and the CPU: pending lines, the interrupt
// request/ack handshake and the SPR access port.
interface mor1kx_pic_scheduler_if;
    logic [31:0] picsr_i;
    logic        irq_req_o;
    logic [4:0]  irq_id_o;
    logic        irq_ack_i;
    logic [2:0]  cur_level_o;
    logic        spr_access_i;
    logic        spr_we_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o;

    modport slave (
        input  picsr_i, irq_ack_i, spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
        output irq_req_o, irq_id_o, cur_level_o, spr_bus_ack, spr_dat_o
    );

    modport master (
        output picsr_i, irq_ack_i, spr_access_i, spr_we_i, spr_addr_i, spr_dat_i,
        input  irq_req_o, irq_id_o, cur_level_o, spr_bus_ack, spr_dat_o
    );
endinterface

// File: rtl/mor1kx_pic_scheduler.sv
// Priority-based PIC scheduler: 2-bit per-line priorities, 4-level in-service
// bitmap with nesting, and an IDLE/ARB/REQ request FSM toward the CPU.
module mor1kx_pic_scheduler #(
    parameter int unsigned OPTION_PIC_NMI_WIDTH          = 0,
    parameter int unsigned OPTION_PIC_FIXED_DEFAULT_PRIO = 0
) (
    input logic                   clk,
    input logic                   rst,
    mor1kx_pic_scheduler_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StArb, StReq} state_e;

    state_e      state_q, state_d;
    logic [4:0]  id_q, id_d;
    logic [1:0]  id_prio_q, id_prio_d;
    logic [3:0]  isr_q, isr_d;
    logic [63:0] prio_q, prio_d;
    logic [63:0] prio_rst;

    logic [10:0] spr_off;
    logic        unused_addr;
    logic        wr_pr0, wr_pr1, wr_eoi;
    logic [2:0]  cur_level;
    logic [3:0]  isr_eoi;
    logic [31:0] elig;
    logic        found;
    logic [4:0]  win_id;
    logic [1:0]  win_prio;
    logic        withdraw;

    assign spr_off     = bus.spr_addr_i[10:0];
    assign unused_addr = ^bus.spr_addr_i[15:11];
    assign wr_pr0 = bus.spr_access_i && bus.spr_we_i && (spr_off == 11'h008);
    assign wr_pr1 = bus.spr_access_i && bus.spr_we_i && (spr_off == 11'h009);
    assign wr_eoi = bus.spr_access_i && bus.spr_we_i && (spr_off == 11'h00a);

    always_comb begin
        prio_rst = '0;
        for (int unsigned k = 0; k < 32; k++) begin
            prio_rst[2*k +: 2] = (k < OPTION_PIC_NMI_WIDTH) ? 2'b11
                                                            : 2'(OPTION_PIC_FIXED_DEFAULT_PRIO);
        end
    end

    // Level = highest in-service priority + 1, so a line is eligible iff prio >= level.
    always_comb begin
        casez (isr_q)
            4'b1???: cur_level = 3'd4;
            4'b01??: cur_level = 3'd3;
            4'b001?: cur_level = 3'd2;
            4'b0001: cur_level = 3'd1;
            default: cur_level = 3'd0;
        endcase
    end

    always_comb begin
        isr_eoi = isr_q;
        if (isr_q[3])      isr_eoi[3] = 1'b0;
        else if (isr_q[2]) isr_eoi[2] = 1'b0;
        else if (isr_q[1]) isr_eoi[1] = 1'b0;
        else if (isr_q[0]) isr_eoi[0] = 1'b0;
    end

    // Scanning downward with >= leaves the lowest line number as the tie winner.
    always_comb begin
        elig     = '0;
        found    = 1'b0;
        win_id   = '0;
        win_prio = '0;
        for (int k = 31; k >= 0; k--) begin
            elig[k] = bus.picsr_i[k] && ({1'b0, prio_q[2*k +: 2]} >= cur_level);
            if (elig[k] && (!found || prio_q[2*k +: 2] >= win_prio)) begin
                found    = 1'b1;
                win_id   = 5'(k);
                win_prio = prio_q[2*k +: 2];
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (wr_pr0) prio_d[31:0]  = bus.spr_dat_i;
        if (wr_pr1) prio_d[63:32] = bus.spr_dat_i;
        for (int unsigned k = 0; k < 32; k++) begin
            if (k < OPTION_PIC_NMI_WIDTH) prio_d[2*k +: 2] = 2'b11;
        end
    end

    // The priority latched at ARB is used in REQ so SPR writes cannot disturb it.
    assign withdraw = !bus.picsr_i[id_q] || ({1'b0, id_prio_q} < cur_level);

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        id_prio_d = id_prio_q;
        isr_d     = wr_eoi ? isr_eoi : isr_q;
        unique case (state_q)
            StIdle: if (found) state_d = StArb;
            StArb: begin
                if (found) begin
                    id_d      = win_id;
                    id_prio_d = win_prio;
                    state_d   = StReq;
                end else begin
                    state_d = StIdle;
                end
            end
            StReq: begin
                if (bus.irq_ack_i) begin
                    isr_d[id_prio_q] = 1'b1;
                    state_d          = StIdle;
                end else if (withdraw) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            id_q      <= '0;
            id_prio_q <= '0;
            isr_q     <= '0;
            prio_q    <= prio_rst;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            id_prio_q <= id_prio_d;
            isr_q     <= isr_d;
            prio_q    <= prio_d;
        end
    end

    assign bus.irq_req_o   = (state_q == StReq);
    assign bus.irq_id_o    = id_q;
    assign bus.cur_level_o = cur_level;
    assign bus.spr_bus_ack = bus.spr_access_i;

    always_comb begin
        bus.spr_dat_o = '0;
        if (bus.spr_access_i) begin
            case (spr_off)
                11'h008: bus.spr_dat_o = prio_q[31:0];
                11'h009: bus.spr_dat_o = prio_q[63:32];
                11'h00a: bus.spr_dat_o = {23'b0, isr_q, id_q};
                default: bus.spr_dat_o = '0;
            endcase
        end
    end

endmodule
